// File: rtl/divf_seq.sv
// divf_seq: sequential IEEE-754 single-precision divider.
// The quotient is formed by restoring division, one bit per cycle, and then truncated.
// Zero and divide-by-zero operand pairs bypass the iteration and finish in one cycle.
module divf_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ready,
  output logic        done,
  output logic [31:0] s
);

  localparam int unsigned MW    = 24;  // mantissa width including hidden 1
  localparam int unsigned QW    = 25;  // quotient width
  localparam int unsigned RW    = 25;  // partial remainder width (< 2*mb)
  localparam int unsigned EW    = 10;  // signed working exponent width
  localparam int unsigned CW    = 5;   // iteration counter width
  localparam int unsigned ITERS = 25;

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t                state;
  logic                  sign;
  logic signed [EW-1:0]  e;
  logic [MW-1:0]         mb;
  logic [RW-1:0]         rem;
  logic [QW-1:0]         q;
  logic [CW-1:0]         cnt;

  logic                  a_zero;
  logic                  b_zero;
  logic                  rem_ge;
  logic [MW-1:0]         rem_keep;
  logic signed [EW-1:0]  exp_n;
  logic [22:0]           frac_n;
  logic [31:0]           special_n;
  logic [31:0]           res_n;

  // Operand classification and the special-pair result for the accept cycle
  always_comb begin
    a_zero    = (a[30:0] == 31'd0);
    b_zero    = (b[30:0] == 31'd0);
    special_n = {a[31] ^ b[31], 31'd0};
    if (!a_zero && b_zero) begin
      special_n = {a[31] ^ b[31], 8'hFF, 23'd0};
    end
  end

  // One restoring-division step: compare, conditionally subtract
  always_comb begin
    rem_ge   = (rem >= {1'b0, mb});
    rem_keep = rem[MW-1:0];
    if (rem_ge) begin
      rem_keep = MW'(rem - {1'b0, mb});
    end
  end

  // Normalisation, truncation, overflow saturation and underflow flush
  always_comb begin
    frac_n = q[22:0];
    exp_n  = e - 10'sd1;
    if (q[QW-1]) begin
      frac_n = q[23:1];
      exp_n  = e;
    end
    if (exp_n >= 10'sd255) begin
      res_n = {sign, 8'hFF, 23'd0};
    end else if (exp_n <= 10'sd0) begin
      res_n = {sign, 31'd0};
    end else begin
      res_n = {sign, exp_n[7:0], frac_n};
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
      s     <= 32'd0;
      sign  <= 1'b0;
      e     <= '0;
      mb    <= '0;
      rem   <= '0;
      q     <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ready <= 1'b0;
            sign  <= a[31] ^ b[31];
            if (a_zero || b_zero) begin
              s     <= special_n;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              e     <= $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;
              mb    <= {1'b1, b[22:0]};
              rem   <= {2'b01, a[22:0]};
              q     <= '0;
              cnt   <= '0;
              state <= DIV;
            end
          end
        end
        DIV: begin
          q   <= {q[QW-2:0], rem_ge};
          rem <= {rem_keep, 1'b0};
          if (cnt == CW'(ITERS - 1)) begin
            state <= NORM;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        NORM: begin
          s     <= res_n;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
